// File: rtl/ddr_axi_pkg.sv
// Shared widths, FSM states and grant encoding for the DDR AXI user-port responder.
// Latency: none (types and constants only); backpressure: not applicable.
package ddr_axi_pkg;

    localparam int DDR_ADDR_W = 28;
    localparam int DDR_DATA_W = 256;
    localparam int DDR_ID_W   = 4;
    localparam int DDR_LEN_W  = 4;

    typedef enum logic [2:0] {INIT, IDLE, WRITE, READ_LAT, READ} state_t;

    typedef enum logic {GNT_WR, GNT_RD} grant_t;

endpackage

// File: rtl/ddr_model_ram.sv
// Single-port byte-enable RAM standing in for DDR storage.
// Latency: 1-cycle registered read; backpressure: none, one access per cycle.
module ddr_model_ram #(
    parameter int DATA_W = 256,
    parameter int MEM_AW = 10,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [MEM_AW-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**MEM_AW];
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Storage is never reset so data survives a responder reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STRB_W; i++) begin
            if (en && we && wstrb[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ddr_axi_responder.sv
// Push-style DDR controller user-port model: arbitrates aw/ar, streams write beats into RAM, returns read bursts.
// Latency: first rvalid RD_LAT cycles after ar handshake; backpressure: none on w/r beats, requests wait for ready.
module ddr_axi_responder
    import ddr_axi_pkg::*;
#(
    parameter int ADDR_W     = DDR_ADDR_W,
    parameter int DATA_W     = DDR_DATA_W,
    parameter int STRB_W     = DATA_W / 8,
    parameter int ID_W       = DDR_ID_W,
    parameter int LEN_W      = DDR_LEN_W,
    parameter int MEM_AW     = 10,
    parameter int ADDR_SHIFT = 3,
    parameter int RD_LAT     = 4,
    parameter int INIT_CYC   = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ddr_init_done,
    input  logic [ADDR_W-1:0] axi_awaddr,
    input  logic              axi_awuser_ap,
    input  logic [ID_W-1:0]   axi_awuser_id,
    input  logic [LEN_W-1:0]  axi_awlen,
    input  logic              axi_awvalid,
    output logic              axi_awready,
    input  logic [DATA_W-1:0] axi_wdata,
    input  logic [STRB_W-1:0] axi_wstrb,
    output logic              axi_wready,
    output logic [ID_W-1:0]   axi_wusero_id,
    output logic              axi_wusero_last,
    input  logic [ADDR_W-1:0] axi_araddr,
    input  logic              axi_aruser_ap,
    input  logic [ID_W-1:0]   axi_aruser_id,
    input  logic [LEN_W-1:0]  axi_arlen,
    input  logic              axi_arvalid,
    output logic              axi_arready,
    output logic [DATA_W-1:0] axi_rdata,
    output logic              axi_rvalid,
    output logic [ID_W-1:0]   axi_rid,
    output logic              axi_rlast
);

    localparam int ICW = $clog2(INIT_CYC + 1);
    localparam int LW  = $clog2(RD_LAT + 1);

    state_t            state_q, state_d;
    grant_t            last_q, last_d;
    logic [ICW-1:0]    init_cnt_q, init_cnt_d;
    logic [LW-1:0]     lat_q, lat_d;
    logic [LEN_W-1:0]  len_q, len_d, beat_q, beat_d;
    logic [MEM_AW-1:0] base_q, base_d;
    logic [ID_W-1:0]   id_q, id_d, wid_q, wid_d, rid_q, rid_d;
    logic init_done_q, init_done_d, awready_q, awready_d, arready_q, arready_d;
    logic wready_q, wready_d, wlast_q, wlast_d, rvalid_q, rvalid_d, rlast_q, rlast_d;

    logic              arb;
    logic              ram_en, ram_we;
    logic [MEM_AW-1:0] ram_addr;
    logic [ADDR_W-1:0] aw_sh, ar_sh;
    logic              unused_sig;

    assign aw_sh      = axi_awaddr >> ADDR_SHIFT;
    assign ar_sh      = axi_araddr >> ADDR_SHIFT;
    assign unused_sig = ^{axi_awuser_ap, axi_aruser_ap, aw_sh, ar_sh};

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        init_cnt_d  = init_cnt_q;
        lat_d       = lat_q;
        len_d       = len_q;
        beat_d      = beat_q;
        base_d      = base_q;
        id_d        = id_q;
        wid_d       = wid_q;
        rid_d       = rid_q;
        init_done_d = init_done_q;
        awready_d   = 1'b0;
        arready_d   = 1'b0;
        wready_d    = wready_q;
        wlast_d     = wlast_q;
        rvalid_d    = rvalid_q;
        rlast_d     = rlast_q;
        arb         = 1'b0;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = base_q + MEM_AW'(beat_q);

        case (state_q)
            INIT: begin
                init_cnt_d = init_cnt_q + ICW'(1);
                if (init_cnt_q == ICW'(INIT_CYC - 1)) begin
                    init_done_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            IDLE: begin
                if (awready_q && axi_awvalid) begin
                    base_d   = aw_sh[MEM_AW-1:0];
                    len_d    = axi_awlen;
                    id_d     = axi_awuser_id;
                    wid_d    = axi_awuser_id;
                    beat_d   = '0;
                    wready_d = 1'b1;
                    wlast_d  = (axi_awlen == '0);
                    last_d   = GNT_WR;
                    state_d  = WRITE;
                end else if (arready_q && axi_arvalid) begin
                    base_d = ar_sh[MEM_AW-1:0];
                    len_d  = axi_arlen;
                    id_d   = axi_aruser_id;
                    beat_d = '0;
                    lat_d  = '0;
                    last_d = GNT_RD;
                    // With a one-cycle latency the first RAM read must be issued in the handshake cycle.
                    if (RD_LAT <= 1) begin
                        ram_en   = 1'b1;
                        ram_addr = ar_sh[MEM_AW-1:0];
                        rvalid_d = 1'b1;
                        rid_d    = axi_aruser_id;
                        rlast_d  = (axi_arlen == '0);
                        state_d  = READ;
                    end else begin
                        state_d = READ_LAT;
                    end
                end else begin
                    arb = !awready_q && !arready_q;
                end
            end
            WRITE: begin
                ram_en = 1'b1;
                ram_we = 1'b1;
                if (beat_q == len_q) begin
                    wready_d = 1'b0;
                    wlast_d  = 1'b0;
                    wid_d    = '0;
                    state_d  = IDLE;
                    arb      = 1'b1;
                end else begin
                    beat_d  = beat_q + LEN_W'(1);
                    wlast_d = (beat_q + LEN_W'(1) == len_q);
                end
            end
            READ_LAT: begin
                lat_d = lat_q + LW'(1);
                if (lat_q == LW'(RD_LAT - 2)) begin
                    ram_en   = 1'b1;
                    ram_addr = base_q;
                    rvalid_d = 1'b1;
                    rid_d    = id_q;
                    rlast_d  = (len_q == '0);
                    state_d  = READ;
                end
            end
            READ: begin
                if (beat_q == len_q) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    rid_d    = '0;
                    state_d  = IDLE;
                    arb      = 1'b1;
                end else begin
                    ram_en   = 1'b1;
                    ram_addr = base_q + MEM_AW'(beat_q + LEN_W'(1));
                    beat_d   = beat_q + LEN_W'(1);
                    rlast_d  = (beat_q + LEN_W'(1) == len_q);
                end
            end
            default: state_d = INIT;
        endcase

        // Contended requests go to the type not served last, so neither side starves.
        if (arb) begin
            if (axi_awvalid && (!axi_arvalid || last_q == GNT_RD)) begin
                awready_d = 1'b1;
            end else if (axi_arvalid) begin
                arready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT;
            last_q      <= GNT_RD;
            init_cnt_q  <= '0;
            lat_q       <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            base_q      <= '0;
            id_q        <= '0;
            wid_q       <= '0;
            rid_q       <= '0;
            init_done_q <= 1'b0;
            awready_q   <= 1'b0;
            arready_q   <= 1'b0;
            wready_q    <= 1'b0;
            wlast_q     <= 1'b0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            init_cnt_q  <= init_cnt_d;
            lat_q       <= lat_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            base_q      <= base_d;
            id_q        <= id_d;
            wid_q       <= wid_d;
            rid_q       <= rid_d;
            init_done_q <= init_done_d;
            awready_q   <= awready_d;
            arready_q   <= arready_d;
            wready_q    <= wready_d;
            wlast_q     <= wlast_d;
            rvalid_q    <= rvalid_d;
            rlast_q     <= rlast_d;
        end
    end

    ddr_model_ram #(
        .DATA_W (DATA_W),
        .MEM_AW (MEM_AW),
        .STRB_W (STRB_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (axi_wdata),
        .wstrb (axi_wstrb),
        .rdata (axi_rdata)
    );

    assign ddr_init_done   = init_done_q;
    assign axi_awready     = awready_q;
    assign axi_arready     = arready_q;
    assign axi_wready      = wready_q;
    assign axi_wusero_id   = wid_q;
    assign axi_wusero_last = wlast_q;
    assign axi_rvalid      = rvalid_q;
    assign axi_rid         = rid_q;
    assign axi_rlast       = rlast_q;

endmodule

// File: tb/tb_ddr_axi_responder.sv
// Directed bench for ddr_axi_responder: init timing, bursts, strobes, arbitration, wrap and reset abort.
module tb_ddr_axi_responder;

    logic         clk;
    logic         rst;
    logic         ddr_init_done;
    logic [27:0]  axi_awaddr;
    logic         axi_awuser_ap;
    logic [3:0]   axi_awuser_id;
    logic [3:0]   axi_awlen;
    logic         axi_awvalid;
    logic         axi_awready;
    logic [255:0] axi_wdata;
    logic [31:0]  axi_wstrb;
    logic         axi_wready;
    logic [3:0]   axi_wusero_id;
    logic         axi_wusero_last;
    logic [27:0]  axi_araddr;
    logic         axi_aruser_ap;
    logic [3:0]   axi_aruser_id;
    logic [3:0]   axi_arlen;
    logic         axi_arvalid;
    logic         axi_arready;
    logic [255:0] axi_rdata;
    logic         axi_rvalid;
    logic [3:0]   axi_rid;
    logic         axi_rlast;

    ddr_axi_responder dut (
        .clk             (clk),
        .rst             (rst),
        .ddr_init_done   (ddr_init_done),
        .axi_awaddr      (axi_awaddr),
        .axi_awuser_ap   (axi_awuser_ap),
        .axi_awuser_id   (axi_awuser_id),
        .axi_awlen       (axi_awlen),
        .axi_awvalid     (axi_awvalid),
        .axi_awready     (axi_awready),
        .axi_wdata       (axi_wdata),
        .axi_wstrb       (axi_wstrb),
        .axi_wready      (axi_wready),
        .axi_wusero_id   (axi_wusero_id),
        .axi_wusero_last (axi_wusero_last),
        .axi_araddr      (axi_araddr),
        .axi_aruser_ap   (axi_aruser_ap),
        .axi_aruser_id   (axi_aruser_id),
        .axi_arlen       (axi_arlen),
        .axi_arvalid     (axi_arvalid),
        .axi_arready     (axi_arready),
        .axi_rdata       (axi_rdata),
        .axi_rvalid      (axi_rvalid),
        .axi_rid         (axi_rid),
        .axi_rlast       (axi_rlast)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    logic [270:0] outs;
    assign outs = {ddr_init_done, axi_awready, axi_arready, axi_wready, axi_wusero_id,
                   axi_wusero_last, axi_rdata, axi_rvalid, axi_rid, axi_rlast};

    int n_vec, n_err;
    logic [255:0] wbeats [16];
    logic [255:0] rbeats [16];

    // Write/read burst observations.
    int   w_tmo, w_hs, w_first, w_end, w_n, w_last_n, w_last_at, w_id_bad;
    logic w_after;
    int   r_tmo, r_hs, r_first, r_end, r_n, r_last_n, r_last_at, r_id_bad;
    logic [8:0] r_after;
    logic [255:0] r_hold;
    // Contended-request observations.
    int   g_n, g_both, g_wr, g_rd;
    int   g_seq [4];

    task automatic wr_burst(input logic [27:0] addr, input logic [3:0] len,
                            input logic [3:0] id, input logic [31:0] strb);
        int guard, beat;
        w_tmo = 0; w_n = 0; w_last_n = 0; w_last_at = -1; w_id_bad = 0;
        axi_awaddr = addr; axi_awlen = len; axi_awuser_id = id; axi_wstrb = strb;
        axi_awvalid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!axi_awready && guard < 100) begin @(negedge clk); guard++; end
        if (!axi_awready) begin w_tmo = 1; axi_awvalid = 1'b0; return; end
        w_hs = cyc;
        @(negedge clk);
        axi_awvalid = 1'b0;
        beat = 0; guard = 0;
        while (beat <= int'(len) && guard < 40) begin
            if (axi_wready) begin
                if (beat == 0) w_first = cyc;
                w_end = cyc;
                axi_wdata = wbeats[beat];
                if (axi_wusero_id !== id) w_id_bad++;
                if (axi_wusero_last) begin w_last_n++; w_last_at = beat; end
                beat++;
            end
            @(negedge clk);
            guard++;
        end
        if (beat <= int'(len)) w_tmo = 1;
        w_n = beat;
        w_after = axi_wready;
    endtask

    task automatic rd_burst(input logic [27:0] addr, input logic [3:0] len, input logic [3:0] id);
        int guard;
        r_tmo = 0; r_n = 0; r_last_n = 0; r_last_at = -1; r_id_bad = 0;
        axi_araddr = addr; axi_arlen = len; axi_aruser_id = id; axi_arvalid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!axi_arready && guard < 100) begin @(negedge clk); guard++; end
        if (!axi_arready) begin r_tmo = 1; axi_arvalid = 1'b0; return; end
        r_hs = cyc;
        @(negedge clk);
        axi_arvalid = 1'b0;
        guard = 0;
        while (r_n <= int'(len) && guard < 40) begin
            if (axi_rvalid) begin
                if (r_n == 0) r_first = cyc;
                r_end = cyc;
                rbeats[r_n] = axi_rdata;
                if (axi_rid !== id) r_id_bad++;
                if (axi_rlast) begin r_last_n++; r_last_at = r_n; end
                r_n++;
            end
            @(negedge clk);
            guard++;
        end
        if (r_n <= int'(len)) r_tmo = 1;
        r_after = {axi_rvalid, axi_rlast, axi_rid, 3'b000};
        r_hold = axi_rdata;
    endtask

    // Serves already-raised awvalid and arvalid (single-beat, zero strobe) and logs grant order.
    task automatic service_both(input int ncyc);
        logic aw_hs, ar_hs;
        aw_hs = 1'b0; ar_hs = 1'b0; g_n = 0; g_both = 0; g_wr = 0; g_rd = 0;
        for (int i = 0; i < 4; i++) g_seq[i] = 9;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (aw_hs) begin axi_awvalid = 1'b0; aw_hs = 1'b0; end
            if (ar_hs) begin axi_arvalid = 1'b0; ar_hs = 1'b0; end
            if (axi_awready && axi_arready) g_both++;
            if (axi_awvalid && axi_awready) begin
                aw_hs = 1'b1;
                if (g_n < 4) g_seq[g_n] = 0;
                g_n++;
            end
            if (axi_arvalid && axi_arready) begin
                ar_hs = 1'b1;
                if (g_n < 4) g_seq[g_n] = 1;
                g_n++;
            end
            if (axi_wready) g_wr++;
            if (axi_rvalid) g_rd++;
        end
    endtask

    task automatic test_reset();
        int early;
        rst = 1'b1;
        axi_awaddr = '0; axi_awuser_ap = 1'b0; axi_awuser_id = '0; axi_awlen = '0; axi_awvalid = 1'b0;
        axi_wdata = '0; axi_wstrb = '0;
        axi_araddr = '0; axi_aruser_ap = 1'b0; axi_aruser_id = '0; axi_arlen = '0; axi_arvalid = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (outs !== '0) begin n_err++; $display("FAIL reset_outs: got %h want 0", outs); end
        // Both requests pending from release: no ready may appear before init completes.
        rst = 1'b0;
        axi_awaddr = 28'h320; axi_awlen = 4'd0; axi_awuser_id = 4'd1; axi_wstrb = 32'h0; axi_awvalid = 1'b1;
        axi_araddr = 28'h320; axi_arlen = 4'd0; axi_aruser_id = 4'd2; axi_arvalid = 1'b1;
        early = 0;
        repeat (15) begin
            @(negedge clk);
            if (axi_awready || axi_arready) early++;
        end
        n_vec++;
        if (ddr_init_done !== 1'b0) begin n_err++; $display("FAIL init_done_early: got %b want 0 after 15 clocks", ddr_init_done); end
        @(negedge clk);
        if (axi_awready || axi_arready) early++;
        n_vec++;
        if (ddr_init_done !== 1'b1) begin n_err++; $display("FAIL init_done_16: got %b want 1 after 16 clocks", ddr_init_done); end
        n_vec++;
        if (early !== 0) begin n_err++; $display("FAIL ready_before_init: got %0d want 0", early); end
        service_both(30);
        n_vec++;
        if (g_seq[0] !== 0 || g_seq[1] !== 1 || g_n !== 2) begin
            n_err++; $display("FAIL reset_grant_order: got %0d,%0d (n=%0d) want 0,1 (n=2)", g_seq[0], g_seq[1], g_n);
        end
        n_vec++;
        if (g_both !== 0 || g_wr !== 1 || g_rd !== 1) begin
            n_err++; $display("FAIL reset_grant_beats: both=%0d wr=%0d rd=%0d want 0,1,1", g_both, g_wr, g_rd);
        end
    endtask

    task automatic test_write_read();
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin b = 8'hA0 + 8'(k); wbeats[k] = {32{b}}; end
        wr_burst(28'h40, 4'd3, 4'd5, 32'hFFFF_FFFF);
        n_vec++;
        if (w_tmo !== 0) begin n_err++; $display("FAIL wr_timeout: got %0d want 0", w_tmo); end
        n_vec++;
        if (w_first - w_hs !== 1) begin n_err++; $display("FAIL wr_first_beat: got %0d want 1", w_first - w_hs); end
        n_vec++;
        if (w_n !== 4 || w_end - w_first !== 3) begin
            n_err++; $display("FAIL wr_beats: got n=%0d span=%0d want 4,3", w_n, w_end - w_first);
        end
        n_vec++;
        if (w_last_n !== 1 || w_last_at !== 3) begin
            n_err++; $display("FAIL wr_last: got cnt=%0d at=%0d want 1,3", w_last_n, w_last_at);
        end
        n_vec++;
        if (w_id_bad !== 0 || w_after !== 1'b0) begin
            n_err++; $display("FAIL wr_id_end: got idbad=%0d wready_after=%b want 0,0", w_id_bad, w_after);
        end
        rd_burst(28'h40, 4'd3, 4'd9);
        n_vec++;
        if (r_tmo !== 0) begin n_err++; $display("FAIL rd_timeout: got %0d want 0", r_tmo); end
        n_vec++;
        if (r_first - r_hs !== 4) begin n_err++; $display("FAIL rd_latency: got %0d want 4", r_first - r_hs); end
        n_vec++;
        if (r_n !== 4 || r_end - r_first !== 3) begin
            n_err++; $display("FAIL rd_beats: got n=%0d span=%0d want 4,3", r_n, r_end - r_first);
        end
        for (int k = 0; k < 4; k++) begin
            b = 8'hA0 + 8'(k);
            n_vec++;
            if (rbeats[k] !== {32{b}}) begin n_err++; $display("FAIL rd_data%0d: got %h want %h", k, rbeats[k], {32{b}}); end
        end
        n_vec++;
        if (r_last_n !== 1 || r_last_at !== 3 || r_id_bad !== 0) begin
            n_err++; $display("FAIL rd_last_id: got cnt=%0d at=%0d idbad=%0d want 1,3,0", r_last_n, r_last_at, r_id_bad);
        end
        n_vec++;
        if (r_after !== 9'h0 || r_hold !== {32{8'hA3}}) begin
            n_err++; $display("FAIL rd_idle: got ctl=%h hold=%h want 0,%h", r_after, r_hold, {32{8'hA3}});
        end
    endtask

    task automatic test_strobe();
        logic [255:0] exp;
        exp = {{28{8'hFF}}, 32'h0000_0000};
        wbeats[0] = {32{8'hFF}};
        wr_burst(28'h40, 4'd0, 4'd1, 32'hFFFF_FFFF);
        n_vec++;
        if (w_last_n !== 1 || w_last_at !== 0) begin
            n_err++; $display("FAIL strb_len0_last: got cnt=%0d at=%0d want 1,0", w_last_n, w_last_at);
        end
        wbeats[0] = '0;
        wr_burst(28'h40, 4'd0, 4'd1, 32'h0000_000F);
        rd_burst(28'h40, 4'd0, 4'd4);
        n_vec++;
        if (rbeats[0] !== exp) begin n_err++; $display("FAIL strb_merge: got %h want %h", rbeats[0], exp); end
        n_vec++;
        if (r_last_n !== 1 || r_last_at !== 0) begin
            n_err++; $display("FAIL rd_len0_last: got cnt=%0d at=%0d want 1,0", r_last_n, r_last_at);
        end
        wbeats[0] = {32{8'h33}};
        wr_burst(28'h40, 4'd0, 4'd1, 32'h0000_0000);
        rd_burst(28'h40, 4'd0, 4'd4);
        n_vec++;
        if (rbeats[0] !== exp) begin n_err++; $display("FAIL strb_zero: got %h want %h", rbeats[0], exp); end
    endtask

    task automatic test_simultaneous();
        // Last served is a write, so the contended pair must start with the read.
        wbeats[0] = '0;
        wr_burst(28'h320, 4'd0, 4'd1, 32'h0);
        axi_awaddr = 28'h320; axi_awlen = 4'd0; axi_awuser_id = 4'd1; axi_wstrb = 32'h0; axi_awvalid = 1'b1;
        axi_araddr = 28'h40; axi_arlen = 4'd0; axi_aruser_id = 4'd2; axi_arvalid = 1'b1;
        service_both(30);
        n_vec++;
        if (g_seq[0] !== 1 || g_seq[1] !== 0 || g_n !== 2) begin
            n_err++; $display("FAIL alt_grant_order: got %0d,%0d (n=%0d) want 1,0 (n=2)", g_seq[0], g_seq[1], g_n);
        end
        n_vec++;
        if (g_both !== 0) begin n_err++; $display("FAIL both_ready: got %0d want 0", g_both); end
    endtask

    task automatic test_wrap();
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin b = 8'h10 + 8'(k); wbeats[k] = {32{b}}; end
        wr_burst(28'h1FF0, 4'd3, 4'd6, 32'hFFFF_FFFF);
        rd_burst(28'h0, 4'd1, 4'd7);
        n_vec++;
        if (rbeats[0] !== {32{8'h12}}) begin n_err++; $display("FAIL wrap_idx0: got %h want %h", rbeats[0], {32{8'h12}}); end
        n_vec++;
        if (rbeats[1] !== {32{8'h13}}) begin n_err++; $display("FAIL wrap_idx1: got %h want %h", rbeats[1], {32{8'h13}}); end
        rd_burst(28'h1FF0, 4'd3, 4'd7);
        for (int k = 0; k < 4; k++) begin
            b = 8'h10 + 8'(k);
            n_vec++;
            if (rbeats[k] !== {32{b}}) begin n_err++; $display("FAIL wrap_rd%0d: got %h want %h", k, rbeats[k], {32{b}}); end
        end
    endtask

    task automatic test_reset_mid_read();
        int guard, nb, seen_last;
        logic [7:0] b;
        for (int k = 0; k < 8; k++) begin b = 8'h50 + 8'(k); wbeats[k] = {32{b}}; end
        wr_burst(28'h80, 4'd7, 4'd2, 32'hFFFF_FFFF);
        axi_araddr = 28'h80; axi_arlen = 4'd7; axi_aruser_id = 4'd3; axi_arvalid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!axi_arready && guard < 50) begin @(negedge clk); guard++; end
        @(negedge clk);
        axi_arvalid = 1'b0;
        nb = 0; guard = 0;
        while (nb < 2 && guard < 20) begin
            if (axi_rvalid) nb++;
            if (nb < 2) begin @(negedge clk); guard++; end
        end
        n_vec++;
        if (nb !== 2) begin n_err++; $display("FAIL mid_read_beat1: got %0d beats want 2", nb); end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (outs !== '0) begin n_err++; $display("FAIL mid_read_reset_outs: got %h want 0", outs); end
        seen_last = 0;
        repeat (3) begin @(negedge clk); if (axi_rlast || axi_wusero_last) seen_last++; end
        n_vec++;
        if (seen_last !== 0) begin n_err++; $display("FAIL mid_read_no_last: got %0d want 0", seen_last); end
        rst = 1'b0;
        guard = 0;
        while (!ddr_init_done && guard < 40) begin @(negedge clk); guard++; end
        n_vec++;
        if (ddr_init_done !== 1'b1) begin n_err++; $display("FAIL reinit_timeout: got %b want 1", ddr_init_done); end
        rd_burst(28'h80, 4'd7, 4'd3);
        for (int k = 0; k < 8; k++) begin
            b = 8'h50 + 8'(k);
            n_vec++;
            if (rbeats[k] !== {32{b}}) begin n_err++; $display("FAIL ram_kept%0d: got %h want %h", k, rbeats[k], {32{b}}); end
        end
        n_vec++;
        if (r_last_n !== 1 || r_last_at !== 7) begin
            n_err++; $display("FAIL reread_last: got cnt=%0d at=%0d want 1,7", r_last_n, r_last_at);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_write_read();
        test_strobe();
        test_simultaneous();
        test_wrap();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
